// File: rtl/cpu_regfile_v2.sv
// 6502 register file: A/X/Y/SP/PC/P with staged PC load, relative branch,
// stack address generation with sticky wrap flags, and P load/push images.
module cpu_regfile_v2 #(
    parameter int unsigned              DATA_W     = 8,
    parameter int unsigned              ADDR_W     = 16,
    parameter logic [ADDR_W-1:0]        RESET_PC   = 16'hFF00,
    parameter logic [DATA_W-1:0]        RESET_SP   = 8'hFF,
    parameter logic [ADDR_W-DATA_W-1:0] STACK_PAGE = 8'h01
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              src_mem,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              load_A,
    input  logic              load_X,
    input  logic              load_Y,
    input  logic              load_SP,
    input  logic              load_PCL,
    input  logic              load_PCH,
    input  logic              inc_PC,
    input  logic              rel_en,
    input  logic              push,
    input  logic              pull,
    input  logic              set_NZ,
    input  logic              set_V,
    input  logic              set_C,
    input  logic              alu_V,
    input  logic              alu_C,
    input  logic [7:0]        flag_set,
    input  logic [7:0]        flag_clr,
    input  logic              load_P,
    input  logic              brk_push,
    output logic [DATA_W-1:0] A_out,
    output logic [DATA_W-1:0] X_out,
    output logic [DATA_W-1:0] Y_out,
    output logic [DATA_W-1:0] SP_out,
    output logic [ADDR_W-1:0] PC_out,
    output logic [7:0]        P_out,
    output logic [7:0]        p_push,
    output logic [ADDR_W-1:0] stack_addr,
    output logic              stk_overflow,
    output logic              stk_underflow
);

    localparam logic [DATA_W-1:0] ONE_D  = 1;
    localparam logic [ADDR_W-1:0] ONE_A  = 1;
    localparam logic [DATA_W-1:0] ZERO_D = '0;
    localparam logic [DATA_W-1:0] ONES_D = '1;
    localparam logic [7:0]        P_RST  = 8'h34;

    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] x_q, x_d;
    logic [DATA_W-1:0] y_q, y_d;
    logic [DATA_W-1:0] sp_q, sp_d;
    logic [DATA_W-1:0] pcl_q, pcl_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [7:0]        p_q, p_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;

    logic [DATA_W-1:0] src;
    logic [DATA_W-1:0] sp_inc;
    logic [DATA_W-1:0] sp_dec;
    logic [ADDR_W-1:0] rel_ext;
    logic [7:0]        alu_mask;
    logic [7:0]        alu_val;
    logic [7:0]        p_ld;

    always_comb begin
        src     = src_mem ? data_in : alu_result;
        sp_inc  = sp_q + ONE_D;
        sp_dec  = sp_q - ONE_D;
        rel_ext = {{(ADDR_W-DATA_W){alu_result[DATA_W-1]}}, alu_result};
    end

    // General-purpose registers and PC low-byte staging latch
    always_comb begin
        a_d   = a_q;
        x_d   = x_q;
        y_d   = y_q;
        pcl_d = pcl_q;
        if (reset) begin
            a_d   = '0;
            x_d   = '0;
            y_d   = '0;
            pcl_d = '0;
        end else begin
            if (load_A)   a_d   = src;
            if (load_X)   x_d   = src;
            if (load_Y)   y_d   = src;
            if (load_PCL) pcl_d = src;
        end
    end

    // PCH always commits the previously staged low byte, even when PCL restages
    always_comb begin
        pc_d = pc_q;
        if (reset) begin
            pc_d = RESET_PC;
        end else if (load_PCH) begin
            pc_d = {src, pcl_q};
        end else if (rel_en) begin
            pc_d = pc_q + rel_ext;
        end else if (inc_PC) begin
            pc_d = pc_q + ONE_A;
        end
    end

    always_comb begin
        sp_d  = sp_q;
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (reset) begin
            sp_d  = RESET_SP;
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end else if (load_SP) begin
            sp_d = src;
        end else if (pull) begin
            sp_d = sp_inc;
            if (sp_q == ONES_D) udf_d = 1'b1;
        end else if (push) begin
            sp_d = sp_dec;
            if (sp_q == ZERO_D) ovf_d = 1'b1;
        end
    end

    // Per-bit priority: load_P > flag_clr > flag_set > ALU update; bit5 is hardwired
    always_comb begin
        alu_mask = {set_NZ, set_V, 4'b0000, set_NZ, set_C};
        alu_val  = {alu_result[DATA_W-1], alu_V, 4'b0000,
                    (alu_result == ZERO_D), alu_C};
        p_ld     = data_in[7:0] | 8'h30;
        if (reset) begin
            p_d = P_RST;
        end else if (load_P) begin
            p_d = p_ld;
        end else begin
            p_d = (((p_q & ~alu_mask) | (alu_val & alu_mask)) | flag_set) & ~flag_clr;
        end
        p_d[5] = 1'b1;
    end

    always_ff @(posedge clk) begin
        a_q   <= a_d;
        x_q   <= x_d;
        y_q   <= y_d;
        sp_q  <= sp_d;
        pcl_q <= pcl_d;
        pc_q  <= pc_d;
        p_q   <= p_d;
        ovf_q <= ovf_d;
        udf_q <= udf_d;
    end

    always_comb begin
        A_out         = a_q;
        X_out         = x_q;
        Y_out         = y_q;
        SP_out        = sp_q;
        PC_out        = pc_q;
        P_out         = p_q;
        stk_overflow  = ovf_q;
        stk_underflow = udf_q;
        p_push        = {p_q[7:6], 1'b1, brk_push, p_q[3:0]};
        stack_addr    = {STACK_PAGE, (pull ? sp_inc : sp_q)};
    end

endmodule

// File: tb/tb_cpu_regfile_v2.sv
// Bench for cpu_regfile_v2: directed scenarios plus randomized run against a behavioural model.
module tb_cpu_regfile_v2;

    logic        clk;
    logic        reset;
    logic        src_mem;
    logic [7:0]  data_in;
    logic [7:0]  alu_result;
    logic        load_A, load_X, load_Y, load_SP;
    logic        load_PCL, load_PCH, inc_PC, rel_en;
    logic        push, pull;
    logic        set_NZ, set_V, set_C, alu_V, alu_C;
    logic [7:0]  flag_set, flag_clr;
    logic        load_P, brk_push;
    logic [7:0]  A_out, X_out, Y_out, SP_out, P_out, p_push;
    logic [15:0] PC_out, stack_addr;
    logic        stk_overflow, stk_underflow;

    int total = 0;
    int bad   = 0;

    // behavioural model state
    int m_a, m_x, m_y, m_sp, m_pc, m_pcl, m_p;
    bit m_of, m_uf;

    cpu_regfile_v2 #(
        .DATA_W(8),
        .ADDR_W(16),
        .RESET_PC(16'hFF00),
        .RESET_SP(8'hFF),
        .STACK_PAGE(8'h01)
    ) dut (
        .clk(clk), .reset(reset), .src_mem(src_mem), .data_in(data_in),
        .alu_result(alu_result), .load_A(load_A), .load_X(load_X),
        .load_Y(load_Y), .load_SP(load_SP), .load_PCL(load_PCL),
        .load_PCH(load_PCH), .inc_PC(inc_PC), .rel_en(rel_en),
        .push(push), .pull(pull), .set_NZ(set_NZ), .set_V(set_V),
        .set_C(set_C), .alu_V(alu_V), .alu_C(alu_C), .flag_set(flag_set),
        .flag_clr(flag_clr), .load_P(load_P), .brk_push(brk_push),
        .A_out(A_out), .X_out(X_out), .Y_out(Y_out), .SP_out(SP_out),
        .PC_out(PC_out), .P_out(P_out), .p_push(p_push),
        .stack_addr(stack_addr), .stk_overflow(stk_overflow),
        .stk_underflow(stk_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        reset = 0; src_mem = 0; data_in = 0; alu_result = 0;
        load_A = 0; load_X = 0; load_Y = 0; load_SP = 0;
        load_PCL = 0; load_PCH = 0; inc_PC = 0; rel_en = 0;
        push = 0; pull = 0; set_NZ = 0; set_V = 0; set_C = 0;
        alu_V = 0; alu_C = 0; flag_set = 0; flag_clr = 0;
        load_P = 0; brk_push = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic set_pc(input logic [15:0] v);
        src_mem = 1; data_in = v[7:0]; load_PCL = 1;
        tick();
        src_mem = 1; data_in = v[15:8]; load_PCH = 1;
        tick();
    endtask

    // Next-state model written straight from the register-file rules
    task automatic model_step();
        int src, off, np;
        src = src_mem ? int'(data_in) : int'(alu_result);
        if (reset) begin
            m_a = 0; m_x = 0; m_y = 0; m_sp = 'hFF; m_pc = 'hFF00;
            m_pcl = 0; m_p = 'h34; m_of = 0; m_uf = 0;
            return;
        end
        if (load_A) m_a = src;
        if (load_X) m_x = src;
        if (load_Y) m_y = src;
        off = (alu_result >= 128) ? int'(alu_result) - 256 : int'(alu_result);
        if (load_PCH)    m_pc = src * 256 + m_pcl;
        else if (rel_en) m_pc = (m_pc + off + 65536) % 65536;
        else if (inc_PC) m_pc = (m_pc + 1) % 65536;
        if (load_PCL) m_pcl = src;
        if (load_SP) m_sp = src;
        else if (pull) begin
            if (m_sp == 255) m_uf = 1;
            m_sp = (m_sp + 1) % 256;
        end else if (push) begin
            if (m_sp == 0) m_of = 1;
            m_sp = (m_sp + 255) % 256;
        end
        np = 0;
        for (int i = 0; i < 8; i++) begin
            int b;
            b = (m_p >> i) & 1;
            if (load_P)                   b = ((int'(data_in) | 'h30) >> i) & 1;
            else if (flag_clr[i])         b = 0;
            else if (flag_set[i])         b = 1;
            else if (set_NZ && i == 7)    b = alu_result >= 128 ? 1 : 0;
            else if (set_NZ && i == 1)    b = alu_result == 0 ? 1 : 0;
            else if (set_V && i == 6)     b = alu_V;
            else if (set_C && i == 0)     b = alu_C;
            if (i == 5) b = 1;
            np += b << i;
        end
        m_p = np;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1;
        tick();
        #1;
        total++; if (PC_out !== 16'hFF00) begin bad++; $display("FAIL reset_pc got=%h exp=ff00", PC_out); end
        total++; if (SP_out !== 8'hFF) begin bad++; $display("FAIL reset_sp got=%h exp=ff", SP_out); end
        total++; if (P_out !== 8'h34) begin bad++; $display("FAIL reset_p got=%h exp=34", P_out); end
        total++; if ({A_out, X_out, Y_out} !== 24'h0) begin bad++; $display("FAIL reset_axy got=%h exp=000000", {A_out, X_out, Y_out}); end
        total++; if (stack_addr !== 16'h01FF) begin bad++; $display("FAIL reset_stack_addr got=%h exp=01ff", stack_addr); end
        total++; if ({stk_overflow, stk_underflow} !== 2'b00) begin bad++; $display("FAIL reset_stk_flags got=%b exp=00", {stk_overflow, stk_underflow}); end
    endtask

    task automatic test_jmp();
        src_mem = 1; data_in = 8'h34; load_PCL = 1;
        tick();
        total++; if (PC_out !== 16'hFF00) begin bad++; $display("FAIL jmp_pcl_only got=%h exp=ff00", PC_out); end
        src_mem = 1; data_in = 8'h12; load_PCH = 1;
        tick();
        total++; if (PC_out !== 16'h1234) begin bad++; $display("FAIL jmp_pc got=%h exp=1234", PC_out); end
        set_pc(16'hFFFF);
        inc_PC = 1;
        tick();
        total++; if (PC_out !== 16'h0000) begin bad++; $display("FAIL inc_wrap got=%h exp=0000", PC_out); end
        src_mem = 1; data_in = 8'hAB; load_PCL = 1;
        tick();
        src_mem = 1; data_in = 8'h56; load_PCL = 1; load_PCH = 1;
        tick();
        total++; if (PC_out !== 16'h56AB) begin bad++; $display("FAIL pcl_pch_same got=%h exp=56ab", PC_out); end
        src_mem = 1; data_in = 8'h78; load_PCH = 1; rel_en = 1; inc_PC = 1; alu_result = 8'h10;
        tick();
        total++; if (PC_out !== 16'h7856) begin bad++; $display("FAIL pch_priority got=%h exp=7856", PC_out); end
    endtask

    task automatic test_branch();
        set_pc(16'h1000);
        rel_en = 1; alu_result = 8'hFE;
        tick();
        total++; if (PC_out !== 16'h0FFE) begin bad++; $display("FAIL branch_back got=%h exp=0ffe", PC_out); end
        set_pc(16'h1000);
        rel_en = 1; alu_result = 8'h7F;
        tick();
        total++; if (PC_out !== 16'h107F) begin bad++; $display("FAIL branch_fwd got=%h exp=107f", PC_out); end
        rel_en = 1; inc_PC = 1; alu_result = 8'h02;
        tick();
        total++; if (PC_out !== 16'h1081) begin bad++; $display("FAIL rel_over_inc got=%h exp=1081", PC_out); end
    endtask

    task automatic test_stack();
        load_SP = 1; alu_result = 8'h00;
        tick();
        total++; if (SP_out !== 8'h00 || stk_overflow !== 1'b0) begin bad++; $display("FAIL loadsp_zero got=%h/%b exp=00/0", SP_out, stk_overflow); end
        push = 1;
        tick();
        total++; if (SP_out !== 8'hFF || stk_overflow !== 1'b1) begin bad++; $display("FAIL push_wrap got=%h/%b exp=ff/1", SP_out, stk_overflow); end
        total++; if (stk_underflow !== 1'b0) begin bad++; $display("FAIL push_no_udf got=%b exp=0", stk_underflow); end
        pull = 1;
        #1;
        total++; if (stack_addr !== 16'h0100) begin bad++; $display("FAIL pull_addr got=%h exp=0100", stack_addr); end
        tick();
        total++; if (SP_out !== 8'h00 || stk_underflow !== 1'b1) begin bad++; $display("FAIL pull_wrap got=%h/%b exp=00/1", SP_out, stk_underflow); end
        load_SP = 1; src_mem = 1; data_in = 8'h10;
        tick();
        push = 1; pull = 1;
        tick();
        total++; if (SP_out !== 8'h11) begin bad++; $display("FAIL push_pull got=%h exp=11", SP_out); end
        #1;
        total++; if (stack_addr !== 16'h0111) begin bad++; $display("FAIL idle_addr got=%h exp=0111", stack_addr); end
        total++; if ({stk_overflow, stk_underflow} !== 2'b11) begin bad++; $display("FAIL sticky got=%b exp=11", {stk_overflow, stk_underflow}); end
    endtask

    task automatic test_flags();
        load_P = 1; data_in = 8'hC3;
        tick();
        total++; if (P_out !== 8'hF3) begin bad++; $display("FAIL load_p got=%h exp=f3", P_out); end
        flag_clr = 8'h80; set_NZ = 1; alu_result = 8'h80;
        tick();
        total++; if (P_out !== 8'h71) begin bad++; $display("FAIL clr_over_nz got=%h exp=71", P_out); end
        brk_push = 0;
        #1;
        total++; if (p_push !== 8'h61) begin bad++; $display("FAIL p_push_nobrk got=%h exp=61", p_push); end
        brk_push = 1;
        #1;
        total++; if (p_push !== 8'h71) begin bad++; $display("FAIL p_push_brk got=%h exp=71", p_push); end
        brk_push = 0;
        set_NZ = 1; alu_result = 8'h00; src_mem = 1; data_in = 8'hFF;
        tick();
        total++; if (P_out !== 8'h73) begin bad++; $display("FAIL nz_zero got=%h exp=73", P_out); end
        set_V = 1; set_C = 1; alu_V = 0; alu_C = 0;
        tick();
        total++; if (P_out !== 8'h32) begin bad++; $display("FAIL vc_clear got=%h exp=32", P_out); end
        flag_set = 8'h80; set_NZ = 1; alu_result = 8'h00;
        tick();
        total++; if (P_out !== 8'hB2) begin bad++; $display("FAIL set_over_nz got=%h exp=b2", P_out); end
        load_P = 1; data_in = 8'h00; flag_set = 8'hFF;
        tick();
        total++; if (P_out !== 8'h30) begin bad++; $display("FAIL loadp_priority got=%h exp=30", P_out); end
    endtask

    task automatic test_reset_mid();
        src_mem = 1; data_in = 8'h55; load_PCL = 1;
        tick();
        reset = 1;
        tick();
        src_mem = 1; data_in = 8'h12; load_PCH = 1;
        tick();
        total++; if (PC_out !== 16'h1200) begin bad++; $display("FAIL reset_mid got=%h exp=1200", PC_out); end
    endtask

    task automatic test_random();
        int exp_sa;
        reset = 1;
        model_step();
        tick();
        for (int n = 0; n < 400; n++) begin
            reset      = ($urandom_range(63) == 0);
            src_mem    = $urandom_range(1);
            data_in    = 8'($urandom);
            alu_result = ($urandom_range(7) == 0) ? 8'h00 : 8'($urandom);
            load_A     = ($urandom_range(3) == 0);
            load_X     = ($urandom_range(3) == 0);
            load_Y     = ($urandom_range(3) == 0);
            load_SP    = ($urandom_range(15) == 0);
            load_PCL   = ($urandom_range(3) == 0);
            load_PCH   = ($urandom_range(5) == 0);
            inc_PC     = $urandom_range(1);
            rel_en     = ($urandom_range(3) == 0);
            push       = ($urandom_range(2) == 0);
            pull       = ($urandom_range(2) == 0);
            set_NZ     = $urandom_range(1);
            set_V      = $urandom_range(1);
            set_C      = $urandom_range(1);
            alu_V      = $urandom_range(1);
            alu_C      = $urandom_range(1);
            flag_set   = ($urandom_range(3) == 0) ? 8'($urandom) : 8'h00;
            flag_clr   = ($urandom_range(3) == 0) ? 8'($urandom) : 8'h00;
            load_P     = ($urandom_range(9) == 0);
            brk_push   = $urandom_range(1);
            #1;
            exp_sa = 'h100 + (pull ? (m_sp + 1) % 256 : m_sp);
            total++; if (stack_addr !== 16'(exp_sa)) begin bad++; $display("FAIL rnd_stack_addr n=%0d got=%h exp=%h", n, stack_addr, 16'(exp_sa)); end
            total++; if (p_push !== 8'((m_p & 'hEF) | 'h20 | (int'(brk_push) << 4))) begin bad++; $display("FAIL rnd_p_push n=%0d got=%h exp=%h", n, p_push, 8'((m_p & 'hEF) | 'h20 | (int'(brk_push) << 4))); end
            model_step();
            tick();
            total++; if ({A_out, X_out, Y_out} !== {8'(m_a), 8'(m_x), 8'(m_y)}) begin bad++; $display("FAIL rnd_axy n=%0d got=%h exp=%h", n, {A_out, X_out, Y_out}, {8'(m_a), 8'(m_x), 8'(m_y)}); end
            total++; if (SP_out !== 8'(m_sp)) begin bad++; $display("FAIL rnd_sp n=%0d got=%h exp=%h", n, SP_out, 8'(m_sp)); end
            total++; if (PC_out !== 16'(m_pc)) begin bad++; $display("FAIL rnd_pc n=%0d got=%h exp=%h", n, PC_out, 16'(m_pc)); end
            total++; if (P_out !== 8'(m_p)) begin bad++; $display("FAIL rnd_p n=%0d got=%h exp=%h", n, P_out, 8'(m_p)); end
            total++; if ({stk_overflow, stk_underflow} !== {m_of, m_uf}) begin bad++; $display("FAIL rnd_stk_flags n=%0d got=%b exp=%b", n, {stk_overflow, stk_underflow}, {m_of, m_uf}); end
        end
    endtask

    initial begin
        clear_inputs();
        #2;
        test_reset();
        test_jmp();
        test_branch();
        test_stack();
        test_flags();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
